// File: rtl/vm_pkg.sv
// vm_pkg: shared vending-machine constants; beep FSM state encoding and standard beep counts
package vm_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;
  localparam logic [2:0] BEEP_COIN = 3'd1;
  localparam logic [2:0] BEEP_VEND = 3'd2;
  localparam logic [2:0] BEEP_ERR  = 3'd3;
endpackage

// File: rtl/tone_divider.sv
// tone_divider: registered square wave sq, high on the first cycle of en, toggling every HALF_PERIOD cycles; sys_clk/sys_rst_n, en in, sq out
module tone_divider #(
  parameter int HALF_PERIOD = 25_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  output logic sq
);
  localparam int W = $clog2(HALF_PERIOD + 1);
  localparam logic [W-1:0] LAST = W'(HALF_PERIOD - 1);
  logic [W-1:0] half_cnt;
  logic act;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sq       <= 1'b0;
      act      <= 1'b0;
      half_cnt <= '0;
    end else if (!en) begin
      sq       <= 1'b0;
      act      <= 1'b0;
      half_cnt <= '0;
    end else if (!act) begin
      sq       <= 1'b1;
      act      <= 1'b1;
      half_cnt <= '0;
    end else if (half_cnt == LAST) begin
      sq       <= ~sq;
      half_cnt <= '0;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/beep_gen.sv
// beep_gen: bursts of 1..7 beeps per request; sys_clk/sys_rst_n, beep_req/beep_num in, buzzer/busy out
module beep_gen
  import vm_pkg::*;
#(
  parameter int HALF_PERIOD = 25_000,
  parameter int TONE_CYCLES = 10_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int CNT_W       = 24
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       beep_req,
  input  logic [2:0] beep_num,
  output logic       buzzer,
  output logic       busy
);
  localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] dur_cnt;
  logic [2:0] rem;
  logic accept, tone_end, gap_end;
  always_comb begin
    accept    = state == ST_IDLE && beep_req && beep_num != 3'd0;
    tone_end  = state == ST_TONE && dur_cnt == TONE_LAST;
    gap_end   = state == ST_GAP && dur_cnt == GAP_LAST;
    state_nxt = accept ? ST_TONE :
                tone_end ? (rem == 3'd1 ? ST_IDLE : ST_GAP) :
                gap_end ? ST_TONE : state;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= ST_IDLE;
      dur_cnt <= '0;
      rem     <= 3'd0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      dur_cnt <= (state_nxt != state || state_nxt == ST_IDLE) ? '0 : dur_cnt + 1'b1;
      rem     <= accept ? beep_num : tone_end ? rem - 1'b1 : rem;
      busy    <= state_nxt != ST_IDLE;
    end
  end
  // Enabled from the next state so the first high half-period lands in the first TONE cycle
  tone_divider #(.HALF_PERIOD(HALF_PERIOD)) u_div (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (state_nxt == ST_TONE),
    .sq       (buzzer)
  );
endmodule
